// File: rtl/decode_bts.sv
// ----------------------------------------------------------------------------
// decode_bts -- receive-side bit unstuffer.
//
// Removes the stuffed 0 that follows every run of MAX_ONES consecutive 1s in
// an NRZI-decoded bit stream. A 1 in the stuffed-bit position is a bit-stuff
// violation. The violation is flagged sticky until the packet is cleared.
//
// Ports
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset
//   d_orig     : received (NRZI-decoded) bit, valid when bit_ready=1
//   bit_ready  : one-cycle strobe per received bit
//   clear      : synchronous packet clear (EOP / new packet)
//   d_out      : last forwarded data bit (registered)
//   bit_ready2 : one-cycle strobe per forwarded bit (registered)
//   stuff_det  : one-cycle pulse when a stuffed 0 has been removed
//   stuff_err  : sticky bit-stuff violation flag
// ----------------------------------------------------------------------------
module decode_bts #(
  parameter int MAX_ONES = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_orig,
  input  logic bit_ready,
  input  logic clear,
  output logic d_out,
  output logic bit_ready2,
  output logic stuff_det,
  output logic stuff_err
);

  localparam int CW = (MAX_ONES < 1) ? 1 : $clog2(MAX_ONES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ONES);

  typedef enum logic [1:0] {
    NORMAL,
    EXPECT_STUFF,
    ERROR
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] ones_reg, ones_next;
  logic [CW-1:0] ones_inc;
  logic          d_out_reg, d_out_next;
  logic          br2_reg, br2_next;
  logic          sd_reg, sd_next;
  logic          err_reg, err_next;

  // Saturating increment: the counter never wraps even if it were to sit
  // at its maximum.
  assign ones_inc = (ones_reg == MAX_CNT) ? ones_reg : ones_reg + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= NORMAL;
      ones_reg  <= '0;
      d_out_reg <= 1'b1;
      br2_reg   <= 1'b0;
      sd_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ones_reg  <= ones_next;
      d_out_reg <= d_out_next;
      br2_reg   <= br2_next;
      sd_reg    <= sd_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ones_next  = ones_reg;
    d_out_next = d_out_reg;
    br2_next   = 1'b0;
    sd_next    = 1'b0;
    err_next   = err_reg;

    if (clear) begin
      // Clear wins over a coincident strobe; that bit is simply lost.
      state_next = NORMAL;
      ones_next  = '0;
      err_next   = 1'b0;
    end else if (bit_ready) begin
      case (state_reg)
        NORMAL: begin
          br2_next   = 1'b1;
          d_out_next = d_orig;
          if (!d_orig) begin
            ones_next = '0;
          end else if (ones_inc == MAX_CNT) begin
            // Run complete: this 1 is forwarded, the next bit must be a 0.
            ones_next  = '0;
            state_next = EXPECT_STUFF;
          end else begin
            ones_next = ones_inc;
          end
        end
        EXPECT_STUFF: begin
          // The stuffed position is never forwarded, whatever its value.
          ones_next = '0;
          if (d_orig) begin
            err_next   = 1'b1;
            state_next = ERROR;
          end else begin
            sd_next    = 1'b1;
            state_next = NORMAL;
          end
        end
        ERROR: begin
          // Dead until clear.
        end
        default: begin
          state_next = NORMAL;
          ones_next  = '0;
        end
      endcase
    end
  end

  assign d_out      = d_out_reg;
  assign bit_ready2 = br2_reg;
  assign stuff_det  = sd_reg;
  assign stuff_err  = err_reg;

endmodule

// File: doc/decode_bts.md
DECODE_BTS -- requirements
Module: decode_bts

Interface
REQ-001 SHALL have parameter MAX_ONES, default 6, meaning the run length of consecutive 1s after which the next received bit is a stuffed 0.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port d_orig  input  1  NRZI-decoded received bit; sampled only when bit_ready=1.
REQ-005 SHALL have port bit_ready  input  1  one-cycle strobe, one per received bit period.
REQ-006 SHALL have port clear  input  1  synchronous packet clear (EOP / new packet).
REQ-007 SHALL have port d_out  output  1  last forwarded (unstuffed) data bit, registered.
REQ-008 SHALL have port bit_ready2  output  1  one-cycle strobe per forwarded bit, registered.
REQ-009 SHALL have port stuff_det  output  1  one-cycle pulse when a stuffed 0 is removed.
REQ-010 SHALL have port stuff_err  output  1  sticky bit-stuff violation flag.

Function
REQ-011 SHALL keep an internal ones counter, width ceil(log2(MAX_ONES+1)), saturating and never wrapping.
REQ-012 SHALL implement three states: NORMAL, EXPECT_STUFF, ERROR.
REQ-013 SHALL hold every state, counter and output value except the pulses (bit_ready2, stuff_det) in any cycle with bit_ready=0 and clear=0.
REQ-014 NORMAL, bit_ready=1, d_orig=0: SHALL forward the bit, reset the counter to 0 and remain in NORMAL.
REQ-015 NORMAL, bit_ready=1, d_orig=1: SHALL forward the bit and increment the counter.
REQ-016 Counter reaching MAX_ONES in NORMAL: SHALL set the counter to 0 and go to EXPECT_STUFF.
REQ-017 Forwarding a bit: in the cycle after the bit_ready strobe, SHALL drive d_out=d_orig and bit_ready2=1 for exactly one cycle, giving a fixed latency of 1 clk.
REQ-018 EXPECT_STUFF, bit_ready=1, d_orig=0: SHALL drop the bit (bit_ready2=0, d_out unchanged), pulse stuff_det for one cycle in the next cycle, and return to NORMAL with counter 0.
REQ-019 EXPECT_STUFF, bit_ready=1, d_orig=1: SHALL drop the bit, set stuff_err=1 in the next cycle, and go to ERROR.
REQ-020 ERROR: SHALL ignore bit_ready, generate no bit_ready2 or stuff_det pulses, and hold stuff_err=1 until clear.
REQ-021 clear=1: SHALL take priority over a coincident bit_ready, dropping that bit, and in the next cycle SHALL set state NORMAL, counter 0, stuff_err 0, bit_ready2 0 and stuff_det 0, with d_out unchanged.
REQ-022 bit_ready2 and stuff_det SHALL never be asserted in the same cycle.
REQ-023 Every output SHALL be driven from a flop, with no combinational path from any input to any output.

Reset
REQ-024 n_rst=0 SHALL asynchronously force state NORMAL, counter 0, d_out=1, bit_ready2=0, stuff_det=0 and stuff_err=0.
REQ-025 After n_rst deassertion, the first bit_ready SHALL be processed as the first bit of a run, with no ones carried over.
REQ-026 Reset asserted mid-run SHALL discard the partial count.

Verification
REQ-027 Bits 0,1,1,0, each with a single bit_ready strobe -> four bit_ready2 pulses, each 1 clk after its strobe; d_out=0,1,1,0; stuff_det=0 and stuff_err=0 throughout.
REQ-028 Six 1s, then 0, then 1 -> six bit_ready2 pulses with d_out=1; one stuff_det pulse and no bit_ready2 for the 0; one bit_ready2 pulse with d_out=1 for the final 1; stuff_err=0.
REQ-029 Seven 1s -> six bit_ready2 pulses, then stuff_err=1 one cycle after the 7th strobe; further strobes produce no pulses; clear -> stuff_err=0, and bit 0 is then forwarded normally.
REQ-030 Five 1s, 0, six 1s, 0 -> twelve bit_ready2 pulses and exactly one stuff_det pulse, for the final 0.
REQ-031 Five 1s, then clear coincident with a 1 strobe -> that bit is dropped with no bit_ready2; a following run of six 1s then 0 is needed before stuff_det=1.
REQ-032 Four 1s, then n_rst pulsed low mid-cycle -> outputs are immediately at reset values; a subsequent 3 ones plus 0 produces no stuff_det and four bit_ready2 pulses.
